// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester round-robin APB master with PREADY timeout
//
// Purpose: shares one APB master port between req0 (core data port) and
// req1 (debug/DMA). A transfer runs IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
// A stalled slave is aborted after TIMEOUT ACCESS cycles with PREADY low,
// and the transfer returns err=1 with rdata=0.
//
// Ports:
//   PCLK, PRESET                    clock, async active-high reset
//   reqN_valid/addr/write/wdata     requester N transfer request (N=0,1)
//   reqN_done/rdata/err             requester N completion pulse and result
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA  APB master outputs
//   PRDATA/PREADY/PSLVERR           APB slave responses
module apb_master_arb #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic        req0_write,
    input  logic [31:0] req0_wdata,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic        req1_write,
    input  logic [31:0] req1_wdata,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [15:0] TO = TIMEOUT[15:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        r_grant;
    logic [15:0] r_count;

    logic        w_grant_any;
    logic        w_grant_sel;
    logic        w_finish;
    logic        w_timeout;
    logic [15:0] w_count_inc;
    logic [31:0] w_rdata;
    logic        w_err;

    // Saturating increment so a long stall with timeout disabled never wraps.
    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

    // Writes and timeouts return zero read data.
    assign w_rdata = (w_timeout || PWRITE) ? 32'd0 : PRDATA;
    assign w_err   = w_timeout | PSLVERR;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_any = 1'b0;
        w_grant_sel = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_grant_any = 1'b1;
                    // On a tie, the requester not granted last time wins.
                    w_grant_sel = req1_valid && (!req0_valid || !r_last_grant);
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                // PREADY takes priority over a timeout hitting on the same edge.
                if (PREADY) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if ((TO != 16'd0) && (w_count_inc == TO)) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_count      <= 16'd0;
            PADDR        <= 32'd0;
            PWRITE       <= 1'b0;
            PWDATA       <= 32'd0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
            req0_rdata   <= 32'd0;
            req1_rdata   <= 32'd0;
            req0_err     <= 1'b0;
            req1_err     <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_grant      <= w_grant_sel;
                r_last_grant <= w_grant_sel;
                PADDR        <= w_grant_sel ? req1_addr  : req0_addr;
                PWRITE       <= w_grant_sel ? req1_write : req0_write;
                PWDATA       <= w_grant_sel ? req1_wdata : req0_wdata;
            end

            if (r_state == S_ACCESS) begin
                if (!PREADY) begin
                    r_count <= w_count_inc;
                end
            end else begin
                r_count <= 16'd0;
            end

            // Results are only written on completion, so they hold until the next done.
            if (w_finish) begin
                if (r_grant) begin
                    req1_rdata <= w_rdata;
                    req1_err   <= w_err;
                end else begin
                    req0_rdata <= w_rdata;
                    req0_err   <= w_err;
                end
            end

            // Bus controls decoded from the next state so they come straight off flops.
            PSEL      <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
            PENABLE   <= (w_state_nxt == S_ACCESS);
            req0_done <= (w_state_nxt == S_DONE) && !r_grant;
            req1_done <= (w_state_nxt == S_DONE) && r_grant;
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed self-checking bench for apb_master_arb
module tb_apb_master_arb;

    logic        PCLK;
    logic        PRESET;
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic        req0_write;
    logic [31:0] req0_wdata;
    logic        req0_done;
    logic [31:0] req0_rdata;
    logic        req0_err;
    logic        req1_valid;
    logic [31:0] req1_addr;
    logic        req1_write;
    logic [31:0] req1_wdata;
    logic        req1_done;
    logic [31:0] req1_rdata;
    logic        req1_err;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    apb_master_arb #(.TIMEOUT(4)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_write (req0_write),
        .req0_wdata (req0_wdata),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_write (req1_write),
        .req1_wdata (req1_wdata),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .req1_err   (req1_err),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESET     = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = 32'd0;
        req0_write = 1'b0;
        req0_wdata = 32'd0;
        req1_valid = 1'b0;
        req1_addr  = 32'd0;
        req1_write = 1'b0;
        req1_wdata = 32'd0;
        PRDATA     = 32'd0;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_psel",    PSEL,       0);
        check("rst_penable", PENABLE,    0);
        check("rst_done0",   req0_done,  0);
        check("rst_done1",   req1_done,  0);
        check("rst_paddr",   PADDR,      0);
        check("rst_pwdata",  PWDATA,     0);
        check("rst_rdata0",  req0_rdata, 0);
        check("rst_err1",    req1_err,   0);
        PRESET = 1'b0;

        // 1: single read, minimum latency
        req0_valid = 1'b1;
        req0_addr  = 32'h0000_1004;
        req0_write = 1'b0;
        PRDATA     = 32'hDEAD_BEEF;
        PREADY     = 1'b1;
        tick();
        check("t1_psel_c1",    PSEL,    1);
        check("t1_penable_c1", PENABLE, 0);
        check("t1_paddr_c1",   PADDR,   32'h0000_1004);
        req0_addr = 32'hFFFF_0000;
        tick();
        check("t1_penable_c2", PENABLE, 1);
        check("t1_paddr_hold", PADDR,   32'h0000_1004);
        tick();
        check("t1_done0_c3", req0_done,  1);
        check("t1_done1_c3", req1_done,  0);
        check("t1_rdata",    req0_rdata, 32'hDEAD_BEEF);
        check("t1_err",      req0_err,   0);
        check("t1_psel_c3",  PSEL,       0);
        req0_valid = 1'b0;
        tick();
        check("t1_done0_c4", req0_done, 0);

        // 2: fairness after reset, both valid continuously
        PRESET = 1'b1;
        tick();
        PRESET     = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 32'h0000_0100;
        req0_write = 1'b0;
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_0200;
        req1_write = 1'b1;
        req1_wdata = 32'h0000_0055;
        PRDATA     = 32'hA5A5_0001;
        PREADY     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = ((k % 2) == 1);
            tick();
            check($sformatf("t2_paddr_%0d", k),  PADDR,  g ? 32'h0000_0200 : 32'h0000_0100);
            check($sformatf("t2_pwrite_%0d", k), PWRITE, {31'd0, g});
            tick();
            tick();
            check($sformatf("t2_done0_%0d", k), req0_done, {31'd0, !g});
            check($sformatf("t2_done1_%0d", k), req1_done, {31'd0, g});
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
        end
        check("t2_rdata0", req0_rdata, 32'hA5A5_0001);
        check("t2_rdata1", req1_rdata, 32'd0);

        // 3: req1 write with three wait states; PREADY lands on the timeout edge
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_2000;
        req1_write = 1'b1;
        req1_wdata = 32'h1234_5678;
        PRDATA     = 32'h0BAD_0BAD;
        PREADY     = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t3_penable_%0d", i), PENABLE,   1);
            check($sformatf("t3_pwdata_%0d", i),  PWDATA,    32'h1234_5678);
            check($sformatf("t3_done1_%0d", i),   req1_done, 0);
        end
        PREADY = 1'b1;
        tick();
        check("t3_done1",  req1_done,  1);
        check("t3_err1",   req1_err,   0);
        check("t3_rdata1", req1_rdata, 0);
        check("t3_psel",   PSEL,       0);
        req1_valid = 1'b0;
        tick();

        // 4: timeout after 4 ACCESS cycles, then a normal transfer
        req0_valid = 1'b1;
        req0_addr  = 32'h0000_3000;
        req0_write = 1'b0;
        PRDATA     = 32'h7777_7777;
        PREADY     = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4_psel_%0d", i), PSEL, 1);
        end
        tick();
        check("t4_psel_drop", PSEL,       0);
        check("t4_done0",     req0_done,  1);
        check("t4_err0",      req0_err,   1);
        check("t4_rdata0",    req0_rdata, 0);
        req0_addr = 32'h0000_3004;
        PREADY    = 1'b1;
        tick();
        tick();
        check("t4_paddr_next", PADDR, 32'h0000_3004);
        tick();
        tick();
        check("t4_done0_next", req0_done,  1);
        check("t4_err0_next",  req0_err,   0);
        check("t4_rdata_next", req0_rdata, 32'h7777_7777);
        req0_valid = 1'b0;
        tick();

        // 5: slave error with data
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_4000;
        req1_write = 1'b0;
        PRDATA     = 32'hCAFE_F00D;
        PREADY     = 1'b1;
        PSLVERR    = 1'b1;
        tick();
        tick();
        tick();
        check("t5_done1",     req1_done,  1);
        check("t5_err1",      req1_err,   1);
        check("t5_rdata1",    req1_rdata, 32'hCAFE_F00D);
        check("t5_err0_hold", req0_err,   0);
        req1_valid = 1'b0;
        PSLVERR    = 1'b0;
        tick();

        // 6: async reset during ACCESS, then tie goes to req0
        req0_valid = 1'b1;
        req0_addr  = 32'h0000_5000;
        PREADY     = 1'b0;
        tick();
        tick();
        check("t6_penable_pre", PENABLE, 1);
        #2;
        PRESET = 1'b1;
        #1;
        check("t6_psel_async",    PSEL,    0);
        check("t6_penable_async", PENABLE, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_nodone_%0d", i), req0_done, 0);
        end
        PRESET     = 1'b0;
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_6000;
        req1_write = 1'b0;
        tick();
        check("t6_tie_paddr", PADDR, 32'h0000_5000);
        check("t6_tie_psel",  PSEL,  1);
        PREADY = 1'b1;
        tick();
        tick();
        check("t6_done0", req0_done, 1);
        check("t6_done1", req1_done, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
